// File: rtl/branch_resolve_arbiter_if.sv
// Request/result bundle for the branch resolve arbiter.
// The slave modport faces the arbiter; the master modport faces the requesters and the consumer.
// With BR_ARB_STATS_EN defined, the resolved/mispredict counters are carried here as well.
interface branch_resolve_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*32-1:0]    req_s1;
    logic [NUM_REQ*32-1:0]    req_s2;
    logic [NUM_REQ*3-1:0]     req_funct3;
    logic [NUM_REQ*32-1:0]    req_pc;
    logic [NUM_REQ*32-1:0]    req_imm;
    logic [NUM_REQ-1:0]       req_pred_taken;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic                     res_valid;
    logic                     res_ready;
    logic                     res_taken;
    logic [31:0]              res_target;
    logic                     res_mispredict;
    logic                     res_illegal;
    logic [TAG_W-1:0]         res_tag;
    logic [SRC_W-1:0]         res_src;
`ifdef BR_ARB_STATS_EN
    logic [31:0]              stat_resolved;
    logic [31:0]              stat_mispredict;
`endif

    modport slave (
        input  flush, req_valid, req_s1, req_s2, req_funct3, req_pc, req_imm,
               req_pred_taken, req_tag, res_ready,
        output req_ready, res_valid, res_taken, res_target, res_mispredict,
               res_illegal, res_tag, res_src
`ifdef BR_ARB_STATS_EN
        , output stat_resolved, stat_mispredict
`endif
    );

    modport master (
        output flush, req_valid, req_s1, req_s2, req_funct3, req_pc, req_imm,
               req_pred_taken, req_tag, res_ready,
        input  req_ready, res_valid, res_taken, res_target, res_mispredict,
               res_illegal, res_tag, res_src
`ifdef BR_ARB_STATS_EN
        , input stat_resolved, stat_mispredict
`endif
    );
endinterface

// File: rtl/branch_resolve_arbiter.sv
// branch_resolve_arbiter: a single RV32I branch comparator shared round-robin between
// NUM_REQ requesters. The granted branch is resolved in the grant cycle and captured
// in a one-entry result register that has valid/ready backpressure.
// Optional feature macro: BR_ARB_STATS_EN adds resolved/mispredict counters.
module branch_resolve_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input logic clk,
    input logic rst,
    branch_resolve_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic               res_valid_q, res_valid_d;
    logic               res_taken_q, res_taken_d;
    logic [31:0]        res_target_q, res_target_d;
    logic               res_mispredict_q, res_mispredict_d;
    logic               res_illegal_q, res_illegal_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic [SRC_W-1:0]   res_src_q, res_src_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
`ifdef BR_ARB_STATS_EN
    logic [31:0]        stat_resolved_q, stat_resolved_d;
    logic [31:0]        stat_mispredict_q, stat_mispredict_d;
`endif

    logic               slot_free, gnt_found, gnt_en;
    logic [SRC_W-1:0]   gnt_idx;
    logic [SRC_W:0]     scan;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [31:0]        s1, s2, pc, imm;
    logic [2:0]         f3;
    logic               pred, taken, illegal;
    logic [TAG_W-1:0]   tag;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping upward.
    // Only valid bits and control feed this, never operands.
    always_comb begin
        slot_free = !res_valid_q || bus.res_ready;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
            if (scan >= (SRC_W+1)'(NUM_REQ)) scan = scan - (SRC_W+1)'(NUM_REQ);
            if (!gnt_found && bus.req_valid[scan[SRC_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[SRC_W-1:0];
            end
        end
        gnt_en = gnt_found && slot_free && !bus.flush && !rst;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready_c[i] = gnt_en && (gnt_idx == SRC_W'(i));
    end

    assign bus.req_ready = req_ready_c;

    // Steer the granted requester's operands into the shared comparator and resolve.
    always_comb begin
        s1 = '0; s2 = '0; pc = '0; imm = '0; f3 = '0; pred = 1'b0; tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == SRC_W'(i)) begin
                s1   = bus.req_s1[i*32 +: 32];
                s2   = bus.req_s2[i*32 +: 32];
                pc   = bus.req_pc[i*32 +: 32];
                imm  = bus.req_imm[i*32 +: 32];
                f3   = bus.req_funct3[i*3 +: 3];
                pred = bus.req_pred_taken[i];
                tag  = bus.req_tag[i*TAG_W +: TAG_W];
            end
        end
        illegal = 1'b0;
        case (f3)
            3'b000:  taken = (s1 == s2);
            3'b001:  taken = (s1 != s2);
            3'b100:  taken = ($signed(s1) <  $signed(s2));
            3'b101:  taken = ($signed(s1) >= $signed(s2));
            3'b110:  taken = (s1 <  s2);
            3'b111:  taken = (s1 >= s2);
            default: begin taken = 1'b0; illegal = 1'b1; end
        endcase
    end

    // Next state of the result slot, rotation pointer and counters.
    always_comb begin
        res_valid_d      = res_valid_q;
        res_taken_d      = res_taken_q;
        res_target_d     = res_target_q;
        res_mispredict_d = res_mispredict_q;
        res_illegal_d    = res_illegal_q;
        res_tag_d        = res_tag_q;
        res_src_d        = res_src_q;
        rr_ptr_d         = rr_ptr_q;
`ifdef BR_ARB_STATS_EN
        stat_resolved_d   = stat_resolved_q;
        stat_mispredict_d = stat_mispredict_q;
        // flush discards rather than consumes
        if (res_valid_q && bus.res_ready && !bus.flush) begin
            stat_resolved_d = stat_resolved_q + 32'd1;
            if (res_mispredict_q) stat_mispredict_d = stat_mispredict_q + 32'd1;
        end
`endif
        if (bus.flush) begin
            res_valid_d = 1'b0;
        end else if (gnt_en) begin
            res_valid_d      = 1'b1;
            res_taken_d      = taken;
            res_target_d     = taken ? (pc + imm) : (pc + 32'd4);
            res_mispredict_d = (taken != pred);
            res_illegal_d    = illegal;
            res_tag_d        = tag;
            res_src_d        = gnt_idx;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end
        if (gnt_en)
            rr_ptr_d = (gnt_idx == SRC_W'(NUM_REQ-1)) ? '0 : SRC_W'(gnt_idx + 1'b1);
    end

    // State registers; reset drops any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q      <= 1'b0;
            res_taken_q      <= 1'b0;
            res_target_q     <= '0;
            res_mispredict_q <= 1'b0;
            res_illegal_q    <= 1'b0;
            res_tag_q        <= '0;
            res_src_q        <= '0;
            rr_ptr_q         <= '0;
`ifdef BR_ARB_STATS_EN
            stat_resolved_q   <= '0;
            stat_mispredict_q <= '0;
`endif
        end else begin
            res_valid_q      <= res_valid_d;
            res_taken_q      <= res_taken_d;
            res_target_q     <= res_target_d;
            res_mispredict_q <= res_mispredict_d;
            res_illegal_q    <= res_illegal_d;
            res_tag_q        <= res_tag_d;
            res_src_q        <= res_src_d;
            rr_ptr_q         <= rr_ptr_d;
`ifdef BR_ARB_STATS_EN
            stat_resolved_q   <= stat_resolved_d;
            stat_mispredict_q <= stat_mispredict_d;
`endif
        end
    end

    assign bus.res_valid      = res_valid_q;
    assign bus.res_taken      = res_taken_q;
    assign bus.res_target     = res_target_q;
    assign bus.res_mispredict = res_mispredict_q;
    assign bus.res_illegal    = res_illegal_q;
    assign bus.res_tag        = res_tag_q;
    assign bus.res_src        = res_src_q;
`ifdef BR_ARB_STATS_EN
    assign bus.stat_resolved   = stat_resolved_q;
    assign bus.stat_mispredict = stat_mispredict_q;
`endif
endmodule

// File: tb/tb_branch_resolve_arbiter.sv
// Bench for branch_resolve_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_branch_resolve_arbiter;
    localparam int N  = 2;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_arbiter_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();
    branch_resolve_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // requester-side stimulus
    logic          v   [N];
    logic [31:0]   s1  [N];
    logic [31:0]   s2  [N];
    logic [31:0]   pc  [N];
    logic [31:0]   imm [N];
    logic [2:0]    f3  [N];
    logic          pt  [N];
    logic [TW-1:0] tg  [N];
    logic          rdy, fl;
    logic [N-1:0]  rdy_seen;

    // reference model state
    logic          m_valid, m_taken, m_misp, m_ill;
    logic [31:0]   m_target;
    logic [TW-1:0] m_tag;
    int            m_src, m_rr;
    logic [31:0]   m_stat_res, m_stat_misp;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // nearest valid requester going upward from the rotation pointer
    function automatic int ref_pick();
        int best = -1;
        int bd = N;
        for (int i = 0; i < N; i++) begin
            int d = (i - m_rr + N) % N;
            if (v[i] && d < bd) begin bd = d; best = i; end
        end
        return best;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]           = v[i];
            bus.req_s1[i*32 +: 32]     = s1[i];
            bus.req_s2[i*32 +: 32]     = s2[i];
            bus.req_pc[i*32 +: 32]     = pc[i];
            bus.req_imm[i*32 +: 32]    = imm[i];
            bus.req_funct3[i*3 +: 3]   = f3[i];
            bus.req_pred_taken[i]      = pt[i];
            bus.req_tag[i*TW +: TW]    = tg[i];
        end
        bus.flush     = fl;
        bus.res_ready = rdy;
    endtask

    task automatic new_req(input int i);
        s1[i]  = ($urandom_range(0, 3) == 0) ? s2[i] : $urandom;
        s2[i]  = $urandom;
        pc[i]  = $urandom & 32'hFFFF_FFFC;
        imm[i] = $urandom;
        f3[i]  = 3'($urandom_range(0, 7));
        pt[i]  = 1'($urandom_range(0, 1));
        tg[i]  = TW'($urandom);
        v[i]   = 1'b1;
    endtask

    // one clock: check grant, advance model at the edge, check result register
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        logic t;
        drive();
        #1;
        g = -1;
        if (!rst && !fl && (!m_valid || rdy)) g = ref_pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        rdy_seen = bus.req_ready;
        chk("req_ready", 32'(rdy_seen), 32'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_taken = 0; m_misp = 0; m_ill = 0; m_target = 0;
            m_tag = 0; m_src = 0; m_rr = 0; m_stat_res = 0; m_stat_misp = 0;
        end else begin
            if (m_valid && rdy && !fl) begin
                m_stat_res++;
                if (m_misp) m_stat_misp++;
            end
            if (fl) m_valid = 0;
            else if (g >= 0) begin
                t        = ref_taken(f3[g], s1[g], s2[g]);
                m_valid  = 1;
                m_taken  = t;
                m_target = t ? pc[g] + imm[g] : pc[g] + 32'd4;
                m_misp   = (t != pt[g]);
                m_ill    = (f3[g] == 3'b010) || (f3[g] == 3'b011);
                m_tag    = tg[g];
                m_src    = g;
            end else if (m_valid && rdy) m_valid = 0;
            if (g >= 0) m_rr = (g + 1) % N;
        end
        #1;
        chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
        if (m_valid) begin
            chk("res_taken",      32'(bus.res_taken),      32'(m_taken));
            chk("res_target",     bus.res_target,          m_target);
            chk("res_mispredict", 32'(bus.res_mispredict), 32'(m_misp));
            chk("res_illegal",    32'(bus.res_illegal),    32'(m_ill));
            chk("res_tag",        32'(bus.res_tag),        32'(m_tag));
            chk("res_src",        32'(bus.res_src),        32'(m_src));
        end
`ifdef BR_ARB_STATS_EN
        chk("stat_resolved",   bus.stat_resolved,   m_stat_res);
        chk("stat_mispredict", bus.stat_mispredict, m_stat_misp);
`endif
    endtask

    task automatic retire();
        for (int i = 0; i < N; i++) if (rdy_seen[i]) v[i] = 1'b0;
    endtask

    logic [31:0] hold_tgt;
    logic [TW-1:0] hold_tag;

    initial begin
        for (int i = 0; i < N; i++) begin
            v[i] = 0; s1[i] = 0; s2[i] = 0; pc[i] = 0; imm[i] = 0; f3[i] = 0; pt[i] = 0; tg[i] = 0;
        end
        rdy = 0; fl = 0; rst = 1;
        m_valid = 0; m_rr = 0; m_src = 0; m_stat_res = 0; m_stat_misp = 0;
        cycle(); cycle();
        chk("rst_valid",  32'(bus.res_valid), 0);
        chk("rst_taken",  32'(bus.res_taken), 0);
        chk("rst_target", bus.res_target, 0);
        chk("rst_misp",   32'(bus.res_mispredict), 0);
        chk("rst_ill",    32'(bus.res_illegal), 0);
        chk("rst_tag",    32'(bus.res_tag), 0);
        chk("rst_src",    32'(bus.res_src), 0);
        rst = 0; rdy = 1;

        // idle
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("idle_ready", 32'(rdy_seen), 0);
            chk("idle_valid", 32'(bus.res_valid), 0);
        end

        // bltu on req0 and blt on req1, both valid: req0 wins first
        v[0] = 1; s1[0] = 32'hFFFF_FFFF; s2[0] = 1; f3[0] = 3'b110; pc[0] = 32'h100; imm[0] = 32'h20;
        pt[0] = 1; tg[0] = 4'h3;
        v[1] = 1; s1[1] = 32'hFFFF_FFFF; s2[1] = 1; f3[1] = 3'b100; pc[1] = 32'h200; imm[1] = 32'hFFFF_FFF0;
        pt[1] = 0; tg[1] = 4'hA;
        cycle();
        chk("first_gnt", 32'(rdy_seen), 32'h1);
        chk("bltu_taken",  32'(bus.res_taken), 0);
        chk("bltu_target", bus.res_target, 32'h104);
        chk("bltu_misp",   32'(bus.res_mispredict), 1);
        retire();
        cycle();
        chk("blt_gnt",    32'(rdy_seen), 32'h2);
        chk("blt_taken",  32'(bus.res_taken), 1);
        chk("blt_target", bus.res_target, 32'h1F0);
        chk("blt_misp",   32'(bus.res_mispredict), 1);
        chk("blt_tag",    32'(bus.res_tag), 32'hA);
        retire();

        // both valid continuously: strict alternation
        new_req(0); new_req(1);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("alt_gnt", 32'(rdy_seen), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("alt_src", 32'(bus.res_src), 32'(k % 2));
            for (int i = 0; i < N; i++) if (rdy_seen[i]) new_req(i);
        end

        // stall: result held, no grants
        rdy = 0;
        hold_tgt = bus.res_target; hold_tag = bus.res_tag;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_gnt",    32'(rdy_seen), 0);
            chk("stall_valid",  32'(bus.res_valid), 1);
            chk("stall_target", bus.res_target, hold_tgt);
            chk("stall_tag",    32'(bus.res_tag), 32'(hold_tag));
        end
        rdy = 1;
        cycle();
        chk("unstall_gnt", 32'(rdy_seen), 32'h1);
        retire();

        // flush with res_valid=1 and req0 valid (req0 carries an illegal funct3)
        new_req(0); f3[0] = 3'b010; pc[0] = 32'h300;
        fl = 1;
        cycle();
        chk("flush_gnt",   32'(rdy_seen), 0);
        chk("flush_valid", 32'(bus.res_valid), 0);
        fl = 0;
        cycle();
        chk("post_flush_gnt", 32'(rdy_seen), 32'h2);
        retire();
        cycle();
        chk("ill_gnt",    32'(rdy_seen), 32'h1);
        chk("ill_flag",   32'(bus.res_illegal), 1);
        chk("ill_taken",  32'(bus.res_taken), 0);
        chk("ill_target", bus.res_target, 32'h304);
        retire();

        // random traffic with backpressure, flushes and occasional reset
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++)
                if (!v[i] && $urandom_range(0, 2) != 0) new_req(i);
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            cycle();
            retire();
        end
        rst = 0; fl = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/branch_resolve_arbiter.md
Name: branch_resolve_arbiter

Overview:
- Shares one RV32I branch comparator between NUM_REQ branch requesters (issue slots / reservation-station entries).
- Arbitrates round-robin and evaluates the selected branch in the same cycle.
- Registers a single-entry resolved-branch result (taken flag, redirect PC, mispredict) with valid/ready backpressure.
- Sits between branch issue and the fetch-redirect / commit logic. Supports pipeline flush.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- TAG_W, 4, width of the per-request tag returned with the result.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kills the in-flight result and blocks acceptance this cycle.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_s1  in  NUM_REQ*32  rs1 operand per requester; slice i = bits [32i+31:32i].
- req_s2  in  NUM_REQ*32  rs2 operand per requester.
- req_funct3  in  NUM_REQ*3  branch funct3 per requester.
- req_pc  in  NUM_REQ*32  branch instruction PC.
- req_imm  in  NUM_REQ*32  sign-extended B-immediate.
- req_pred_taken  in  NUM_REQ  predicted direction.
- req_tag  in  NUM_REQ*TAG_W  requester tag.
- res_valid  out  1  result register holds a resolved branch.
- res_ready  in  1  consumer accepts the result.
- res_taken  out  1  resolved direction.
- res_target  out  32  redirect PC: pc+imm if taken, else pc+4.
- res_mispredict  out  1  res_taken != predicted taken.
- res_illegal  out  1  funct3 was 010 or 011.
- res_tag  out  TAG_W  tag of the resolved request.
- res_src  out  $clog2(NUM_REQ)  index of the granted requester.

Behaviour:
- Comparator semantics, by funct3:
  - 000 beq: equal.
  - 001 bne: not equal.
  - 100 blt: signed <.
  - 101 bge: signed >=.
  - 110 bltu: unsigned <.
  - 111 bgeu: unsigned >=.
  - 010/011: taken = 0 and illegal = 1.
- Arithmetic: all adds are 32-bit and wrap modulo 2^32. Target = pc + imm; fallthrough = pc + 4.
- Slot free condition: slot_free = !res_valid || res_ready.
- Grant:
  - Only when slot_free && !flush && any req_valid.
  - Grant goes to the first valid requester at or after rr_ptr, searching upward with wrap.
  - req_ready is one-hot for the granted index, else all zero.
  - req_ready is combinational on req_valid, rr_ptr, res_valid, res_ready and flush.
  - req_ready never depends on the operand inputs.
- Handshake:
  - A request transfers when req_valid[i] && req_ready[i].
  - A requester must hold valid and its operands stable until granted.
  - A requester may not withdraw valid before the grant.
- Latency:
  - The compare is computed combinationally on the granted slice and captured at the grant edge.
  - res_valid is asserted the cycle after grant: 1-cycle latency.
  - Back-to-back throughput is 1 branch/cycle while res_ready = 1.
- Result register:
  - On transfer: load all res_* fields and set res_valid = 1.
  - Else if res_valid && res_ready: clear res_valid.
  - Fields hold while res_valid && !res_ready (stall).
- Round-robin pointer:
  - On grant to index g: rr_ptr <= (g+1) mod NUM_REQ.
  - rr_ptr is unchanged otherwise, including on flush.
- Flush:
  - Next cycle res_valid = 0, whether or not res_ready was asserted.
  - No grant is issued in the flush cycle.
  - res_* data fields may hold stale values.
- Simultaneous flush and res_ready: flush wins; the result counts as discarded, not consumed.
- Reset:
  - res_valid = 0, rr_ptr = 0.
  - res_taken, res_mispredict, res_illegal = 0; res_target = 0; res_tag = 0; res_src = 0.
  - req_ready = 0 during the rst cycle.
  - A reset mid-stall drops the pending result.
- Boundaries:
  - No valid requests: no grant, state holds.
  - All requesters valid: strict rotation 0,1,…,N-1,0.

Optional Feature:
- Macro: BR_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_resolved (32 bits) and stat_mispredict (32 bits).
  - Counters increment when a result is consumed (res_valid && res_ready && !flush). stat_mispredict increments only if res_mispredict.
  - Counters wrap at 2^32 and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, no requests: req_ready = 0, res_valid = 0 for 10 cycles; rr_ptr remains 0, so the first grant goes to req 0 when both are valid.
- Req0 bltu, s1=0xFFFFFFFF, s2=1, pc=0x100, imm=0x20, pred=1 -> next cycle res_taken = 0, res_target = 0x104, res_mispredict = 1.
- Req1 blt with the same operands, pc=0x200, imm=0xFFFFFFF0, pred=0 -> res_taken = 1, res_target = 0x1F0, res_mispredict = 1.
- Both valid continuously, res_ready = 1 -> grants alternate 0,1,0,1; res_src follows the same sequence with 1-cycle lag.
- res_ready = 0 for 3 cycles with res_valid = 1 -> req_ready = 0, res_* fields stable; res_ready = 1 -> consumed and new grant in the same cycle.
- flush while res_valid = 1 and req0 valid -> no grant, next cycle res_valid = 0, rr_ptr unchanged. funct3 = 010 -> res_illegal = 1, res_taken = 0, res_target = pc+4.
